// File: rtl/logica_simple_seq_if.sv
// rtl/logica_simple_seq_if.sv - control, stimulus/response and result-record signals of the sweep sequencer
interface logica_simple_seq_if;
    logic       start;
    logic       abort;
    logic [2:0] abc;
    logic [2:0] xyz;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic [7:0] signature;

    modport slave (
        input  start, abort, xyz, out_ready,
        output abc, busy, done, out_valid, out_data, signature
    );

    modport master (
        output start, abort, xyz, out_ready,
        input  abc, busy, done, out_valid, out_data, signature
    );
endinterface

// File: rtl/logica_simple_seq.sv
// rtl/logica_simple_seq.sv - sweeps abc through 0..7, dwells, captures xyz and emits one record per vector
module logica_simple_seq #(
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    logica_simple_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] xyz_q, xyz_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] sig_q, sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            xyz_q   <= '0;
            dwell_q <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            xyz_q   <= xyz_d;
            dwell_q <= dwell_d;
            sig_q   <= sig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        xyz_d   = xyz_q;
        dwell_d = dwell_q;
        sig_d   = sig_q;
        // abort wins over everything, including a start seen in IDLE
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_d   = '0;
                        dwell_d = '0;
                        sig_d   = '0;
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        xyz_d   = bus.xyz;
                        state_d = EMIT;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        sig_d = {sig_q[6:0], sig_q[7]} ^ {5'b0, xyz_q};
                        if (idx_q == 3'd7) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            dwell_d = '0;
                            state_d = DRIVE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.abc       = (state_q == DRIVE || state_q == EMIT) ? idx_q : 3'b000;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = (state_q == EMIT) ? {idx_q, xyz_q} : 6'b0;
    assign bus.signature = sig_q;
endmodule

// File: tb/tb_logica_simple_seq.sv
// tb/tb_logica_simple_seq.sv - scoreboard bench for logica_simple_seq with DWELL=4 and DWELL=1 instances
module tb_logica_simple_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logica_simple_seq_if bus0();
    logica_simple_seq_if bus1();

    logica_simple_seq #(.DWELL(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    logica_simple_seq #(.DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // combinational logic under control: a lookup table for dut0, inversion for dut1
    logic [2:0] lut [8];
    assign bus0.xyz = lut[bus0.abc];
    assign bus1.xyz = ~bus1.abc;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp0_q[$], exp1_q[$], got0[$], got1[$];
    int rec0 = 0, rec1 = 0, done0 = 0, done1 = 0;
    logic [5:0] e0, e1, held0;
    bit stall0 = 1'b0;
    logic [5:0] nom_tbl [8] = '{6'h07, 6'h0E, 6'h15, 6'h1C, 6'h23, 6'h2A, 6'h31, 6'h38};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // signature after n accepted records: rotate left by one, then fold in the response
    function automatic logic [7:0] sig_model(input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            s = (((s << 1) | (s >> 7)) & 8'hFF) ^ int'(lut[i]);
        return 8'(s);
    endfunction

    initial forever begin
        @(negedge clk);
        if (bus0.done) done0++;
        if (bus0.out_valid && bus0.out_ready) begin
            rec0++;
            got0.push_back(bus0.out_data);
            stall0 = 1'b0;
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 record: got 0x%0h with no record expected", bus0.out_data);
            end else begin
                e0 = exp0_q.pop_front();
                chk("dut0 record", bus0.out_data, e0);
                chk("dut0 abc in EMIT", bus0.abc, e0[5:3]);
            end
        end else if (bus0.out_valid) begin
            if (stall0) chk("dut0 stalled data hold", bus0.out_data, held0);
            stall0 = 1'b1;
            held0  = bus0.out_data;
        end else begin
            stall0 = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus1.done) done1++;
        if (bus1.out_valid && bus1.out_ready) begin
            rec1++;
            got1.push_back(bus1.out_data);
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 record: got 0x%0h with no record expected", bus1.out_data);
            end else begin
                e1 = exp1_q.pop_front();
                chk("dut1 record", bus1.out_data, e1);
            end
        end
    end

    task automatic start0();
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        chk("busy after start", bus0.busy, 1);
        chk("abc at sweep start", bus0.abc, 0);
    endtask

    task automatic sweep0(input int stall_at, input bit spam, input int exp_edges);
        int  n = 0;
        int  r0 = rec0;
        bit  stalled = 1'b0;
        for (int i = 0; i < 8; i++) exp0_q.push_back({3'(i), lut[i]});
        start0();
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (bus0.done) break;
            if (stall_at >= 0 && !stalled && bus0.out_valid && bus0.abc == 3'(stall_at)) begin
                bus0.out_ready = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    n++;
                    chk("stall out_valid", bus0.out_valid, 1);
                    chk("stall out_data", bus0.out_data, {3'(stall_at), lut[stall_at]});
                    chk("stall abc", bus0.abc, stall_at);
                end
                bus0.out_ready = 1'b1;
                stalled = 1'b1;
            end
            bus0.start = spam && ($urandom_range(0, 3) == 0);
        end
        bus0.start = 1'b0;
        chk("edges from start to done", n, exp_edges);
        chk("final signature", bus0.signature, sig_model(8));
        @(posedge clk);
        #1;
        chk("done is one cycle", bus0.done, 0);
        chk("idle after done", bus0.busy, 0);
        chk("records per sweep", rec0 - r0, 8);
        chk("scoreboard drained", exp0_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, d, r;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.out_ready = 1'b1;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) lut[i] = ~3'(i);

        #1;
        chk("reset abc", bus0.abc, 0);
        chk("reset busy", bus0.busy, 0);
        chk("reset done", bus0.done, 0);
        chk("reset out_valid", bus0.out_valid, 0);
        chk("reset out_data", bus0.out_data, 0);
        chk("reset signature", bus0.signature, 0);
        chk("reset busy dut1", bus1.busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal sweep against the published record table
        got0.delete();
        sweep0(-1, 1'b0, 40);
        for (int k = 0; k < 8; k++) chk("nominal record table", got0[k], nom_tbl[k]);
        chk("nominal signature", bus0.signature, 8'hF0);

        // backpressure at idx 3
        sweep0(3, 1'b0, 50);
        chk("backpressure signature", bus0.signature, 8'hF0);

        // randomised response tables, random stall point, start pulses while busy
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) lut[i] = 3'($urandom_range(0, 7));
            sweep0(int'($urandom_range(0, 7)), k == 1, 50);
        end

        // DWELL=1 instance
        r = rec1;
        got1.delete();
        for (int i = 0; i < 8; i++) exp1_q.push_back({3'(i), ~3'(i)});
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus1.done) break;
        end
        chk("dwell1 edges to done", n, 16);
        chk("dwell1 signature", bus1.signature, 8'hF0);
        for (int k = 0; k < 8; k++) chk("dwell1 record table", got1[k], nom_tbl[k]);
        chk("dwell1 record count", rec1 - r, 8);

        // abort in DRIVE at idx 5
        for (int i = 0; i < 8; i++) lut[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) exp0_q.push_back({3'(i), lut[i]});
        d = done0;
        start0();
        n = 0;
        while (n < 200 && !(bus0.busy && bus0.abc == 3'd5 && !bus0.out_valid)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort reached idx5 in time", n < 200, 1);
        bus0.abort = 1'b1;
        @(posedge clk);
        #1;
        bus0.abort = 1'b0;
        chk("abort busy", bus0.busy, 0);
        chk("abort abc", bus0.abc, 0);
        chk("abort out_valid", bus0.out_valid, 0);
        chk("abort keeps signature", bus0.signature, sig_model(5));
        exp0_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("no done after abort", done0 - d, 0);
        sweep0(-1, 1'b0, 40);

        // start and abort together in IDLE
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        chk("start+abort stays idle", bus0.busy, 0);
        @(posedge clk);
        #1;
        chk("start+abort still idle", bus0.busy, 0);

        // asynchronous reset between edges while EMIT is stalled at idx 2
        for (int i = 0; i < 8; i++) lut[i] = ~3'(i);
        for (int i = 0; i < 8; i++) exp0_q.push_back({3'(i), lut[i]});
        d = done0;
        start0();
        n = 0;
        while (n < 200 && !(bus0.out_valid && bus0.abc == 3'd2)) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus0.out_ready = 1'b0;
        chk("reset test reached EMIT idx2", n < 200, 1);
        chk("signature before reset", bus0.signature, sig_model(2));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset abc", bus0.abc, 0);
        chk("async reset busy", bus0.busy, 0);
        chk("async reset done", bus0.done, 0);
        chk("async reset out_valid", bus0.out_valid, 0);
        chk("async reset out_data", bus0.out_data, 0);
        chk("async reset signature", bus0.signature, 0);
        exp0_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus0.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no done after reset", done0 - d, 0);
        chk("idle after reset", bus0.busy, 0);
        sweep0(-1, 1'b0, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
